// File: rtl/stream_ctrl_mf_pkg.sv
// Shared definitions for the multi-frame stream gate: acquisition mode codes,
// FSM state encoding and a helper that folds the reserved mode onto continuous.
package stream_ctrl_pkg;

    localparam logic [1:0] ACQ_CONT   = 2'd0;
    localparam logic [1:0] ACQ_SINGLE = 2'd1;
    localparam logic [1:0] ACQ_MULTI  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Mode 3 is reserved and behaves exactly like continuous acquisition.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? ACQ_CONT : mode;
    endfunction

endpackage

// File: rtl/stream_ctrl_mf_if.sv
// Signal bundle between the sensor-side controls and the stream gate.
// The slave modport is the gate's view; the master modport is the driver's view.
interface stream_ctrl_mf_if #(
    parameter int REG_WD  = 32,
    parameter int TIS_WD  = 3,
    parameter int FCNT_WD = 16
);

    logic               i_fval;
    logic               i_acquisition_start;
    logic               i_stream_enable;
    logic               i_encrypt_state;
    logic [1:0]         iv_acq_mode;
    logic [FCNT_WD-1:0] iv_frame_num;
    logic [REG_WD-1:0]  iv_pixel_format;
    logic [TIS_WD-1:0]  iv_test_image_sel;
    logic               o_enable;
    logic               o_full_frame_state;
    logic [REG_WD-1:0]  ov_pixel_format;
    logic [TIS_WD-1:0]  ov_test_image_sel;
    logic [FCNT_WD-1:0] ov_frame_cnt;
    logic               o_acq_done;

    modport slave (
        input  i_fval, i_acquisition_start, i_stream_enable, i_encrypt_state,
        input  iv_acq_mode, iv_frame_num, iv_pixel_format, iv_test_image_sel,
        output o_enable, o_full_frame_state, ov_pixel_format, ov_test_image_sel,
        output ov_frame_cnt, o_acq_done
    );

    modport master (
        output i_fval, i_acquisition_start, i_stream_enable, i_encrypt_state,
        output iv_acq_mode, iv_frame_num, iv_pixel_format, iv_test_image_sel,
        input  o_enable, o_full_frame_state, ov_pixel_format, ov_test_image_sel,
        input  ov_frame_cnt, o_acq_done
    );

endinterface

// File: rtl/stream_ctrl_mf_fval_gap_det.sv
// Frame-gap detector. Produces the gap-detect FVAL (fval_g) and a one-cycle
// fall indication in the first cycle fval_g is low.
// With STREAM_CTRL_FVAL_HOLD_EN defined, FVAL is stretched by FVAL_HOLD cycles
// through a shift register so trailing line/pipeline data clears before the
// gap is acted on.
module fval_gap_det #(
`ifdef STREAM_CTRL_FVAL_HOLD_EN
    parameter int FVAL_HOLD = 20
`endif
) (
    input  logic clk_pix,
    input  logic reset_pix,
    input  logic i_fval,
    output logic o_fval_g,
    output logic o_fval_fall
);

    logic fval_d;
    logic fval_q;

`ifdef STREAM_CTRL_FVAL_HOLD_EN
    logic [FVAL_HOLD-1:0] hold_d;
    logic [FVAL_HOLD-1:0] hold_q;

    // Shift raw FVAL along the hold line, one stage per pixel clock.
    always_comb begin
        hold_d    = hold_q;
        hold_d[0] = i_fval;
        for (int i = 1; i < FVAL_HOLD; i++) begin
            hold_d[i] = hold_q[i-1];
        end
    end

    // Hold line storage.
    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign o_fval_g = i_fval | hold_q[FVAL_HOLD-1];
`else
    assign o_fval_g = i_fval;
`endif

    // Previous gap-detect FVAL, used to find its falling edge.
    always_comb begin
        fval_d = o_fval_g;
    end

    // Edge-detect register.
    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            fval_q <= 1'b0;
        end else begin
            fval_q <= fval_d;
        end
    end

    assign o_fval_fall = fval_q & ~o_fval_g;

endmodule

// File: rtl/stream_ctrl_mf.sv
// Multi-frame stream gate. Passes only whole frames, shadows the format and
// test-image registers during frame gaps, and runs continuous, single-frame
// or multi-frame acquisitions with a saturating frame counter and done pulse.
// Optional macro: STREAM_CTRL_FVAL_HOLD_EN (stretches FVAL for gap detection).
import stream_ctrl_pkg::*;

module stream_ctrl_mf #(
    parameter int REG_WD  = 32,
    parameter int TIS_WD  = 3,
    parameter int FCNT_WD = 16
`ifdef STREAM_CTRL_FVAL_HOLD_EN
    ,
    parameter int FVAL_HOLD = 20
`endif
) (
    input  logic             clk_pix,
    input  logic             reset_pix,
    stream_ctrl_mf_if.slave  bus
);

    logic               fval_g;
    logic               fval_fall;
    logic               go;
    logic               acq_edge;
    logic [1:0]         live_mode;
    logic [FCNT_WD-1:0] live_target;
    logic [FCNT_WD-1:0] cnt_inc;
    logic [FCNT_WD-1:0] cnt_next;
    logic               count_hit;

    state_t             state_d,     state_q;
    logic               enable_d,    enable_q;
    logic               full_d,      full_q;
    logic               done_d,      done_q;
    logic [FCNT_WD-1:0] cnt_d,       cnt_q;
    logic [1:0]         mode_d,      mode_q;
    logic [FCNT_WD-1:0] target_d,    target_q;
    logic               acq_start_d, acq_start_q;
    logic               arm_flag_d,  arm_flag_q;
    logic [REG_WD-1:0]  pix_fmt_d,   pix_fmt_q;
    logic [TIS_WD-1:0]  tis_d,       tis_q;

`ifdef STREAM_CTRL_FVAL_HOLD_EN
    fval_gap_det #(.FVAL_HOLD(FVAL_HOLD)) u_gap_det (
`else
    fval_gap_det u_gap_det (
`endif
        .clk_pix     (clk_pix),
        .reset_pix   (reset_pix),
        .i_fval      (bus.i_fval),
        .o_fval_g    (fval_g),
        .o_fval_fall (fval_fall)
    );

    assign go          = bus.i_acquisition_start & bus.i_stream_enable & bus.i_encrypt_state;
    assign acq_edge    = bus.i_acquisition_start & ~acq_start_q;
    assign live_mode   = norm_mode(bus.iv_acq_mode);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + FCNT_WD'(1);
    assign cnt_next    = fval_fall ? cnt_inc : cnt_q;
    assign count_hit   = (mode_q != ACQ_CONT) && (cnt_next >= target_q);

    // Frames to capture for a bounded acquisition; a zero frame number means one.
    always_comb begin
        live_target = FCNT_WD'(1);
        if (live_mode == ACQ_MULTI && bus.iv_frame_num != '0) begin
            live_target = bus.iv_frame_num;
        end
    end

    // Next-state, gating and counter logic; stops only ever land in a frame gap.
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        target_d    = target_q;
        full_d      = full_q;
        acq_start_d = bus.i_acquisition_start;
        pix_fmt_d   = fval_g ? pix_fmt_q : bus.iv_pixel_format;
        tis_d       = fval_g ? tis_q : bus.iv_test_image_sel;

        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                if (go && (live_mode == ACQ_CONT || arm_flag_q)) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                if (!go) begin
                    state_d = IDLE;
                end else if (!fval_g) begin
                    state_d  = ACTIVE;
                    enable_d = 1'b1;
                    mode_d   = live_mode;
                    target_d = live_target;
                end
            end
            ACTIVE: begin
                if (fval_fall) begin
                    cnt_d = cnt_inc;
                end
                if (!go || count_hit) begin
                    if (!fval_g) begin
                        state_d  = IDLE;
                        enable_d = 1'b0;
                        done_d   = count_hit;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fval_fall) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            end
        endcase

        if (fval_fall) begin
            full_d = 1'b0;
        end else if (enable_q && bus.i_fval) begin
            full_d = 1'b1;
        end

        arm_flag_d = acq_edge | (arm_flag_q & ~done_d);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= ACQ_CONT;
            target_q    <= '0;
            acq_start_q <= 1'b0;
            arm_flag_q  <= 1'b0;
            pix_fmt_q   <= '0;
            tis_q       <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            full_q      <= full_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            acq_start_q <= acq_start_d;
            arm_flag_q  <= arm_flag_d;
            pix_fmt_q   <= pix_fmt_d;
            tis_q       <= tis_d;
        end
    end

    assign bus.o_enable           = enable_q;
    assign bus.o_full_frame_state = full_q;
    assign bus.o_acq_done         = done_q;
    assign bus.ov_frame_cnt       = cnt_q;
    assign bus.ov_pixel_format    = pix_fmt_q;
    assign bus.ov_test_image_sel  = tis_q;

endmodule

// File: tb/tb_stream_ctrl_mf.sv
// Directed bench for the multi-frame stream gate: continuous, multi-frame,
// enable drop, shadowing, licence block, zero frame number and reset mid-frame.
module tb_stream_ctrl_mf;

    localparam int REG_WD  = 32;
    localparam int TIS_WD  = 3;
    localparam int FCNT_WD = 16;
    localparam int H       = 50;
    localparam int L       = 60;
`ifdef STREAM_CTRL_FVAL_HOLD_EN
    localparam int HOLD    = 20;
`else
    localparam int HOLD    = 0;
`endif
    localparam int D       = HOLD + 1;

    logic clk_pix   = 1'b0;
    logic reset_pix = 1'b1;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_seen  = 0;
    int full_rises = 0;
    int en_cycles  = 0;
    logic full_prev = 1'b0;

    always #5 clk_pix = ~clk_pix;

    stream_ctrl_mf_if #(.REG_WD(REG_WD), .TIS_WD(TIS_WD), .FCNT_WD(FCNT_WD)) bus_if ();

    stream_ctrl_mf #(.REG_WD(REG_WD), .TIS_WD(TIS_WD), .FCNT_WD(FCNT_WD)) dut (
        .clk_pix   (clk_pix),
        .reset_pix (reset_pix),
        .bus       (bus_if)
    );

    // Event counters sampled on the inactive edge.
    always @(negedge clk_pix) begin
        if (bus_if.o_acq_done === 1'b1) done_seen++;
        if (bus_if.o_enable === 1'b1) en_cycles++;
        if (bus_if.o_full_frame_state === 1'b1 && full_prev !== 1'b1) full_rises++;
        full_prev = bus_if.o_full_frame_state;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic test_reset();
        bus_if.i_fval = 0; bus_if.i_acquisition_start = 0; bus_if.i_stream_enable = 0;
        bus_if.i_encrypt_state = 0; bus_if.iv_acq_mode = 0; bus_if.iv_frame_num = 0;
        bus_if.iv_pixel_format = 0; bus_if.iv_test_image_sel = 0;
        reset_pix = 1;
        cyc(2);
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_enable: got %0d want 0", bus_if.o_enable); end
        n_checks++; if (bus_if.o_full_frame_state !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %0d want 0", bus_if.o_full_frame_state); end
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus_if.ov_frame_cnt); end
        n_checks++; if (bus_if.o_acq_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0d want 0", bus_if.o_acq_done); end
        n_checks++; if (bus_if.ov_pixel_format !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_fmt: got %0h want 0", bus_if.ov_pixel_format); end
        reset_pix = 0;
        cyc(L);
    endtask

    task automatic test_cont_mid_frame();
        bus_if.iv_acq_mode = 0;
        bus_if.i_fval = 1;
        cyc(5);
        bus_if.i_acquisition_start = 1; bus_if.i_stream_enable = 1; bus_if.i_encrypt_state = 1;
        en_cycles = 0; done_seen = 0; full_rises = 0;
        cyc(20);
        n_checks++; if (en_cycles !== 0) begin n_fail++; $display("[TB] FAIL cont_no_mid_frame_enable: got %0d cycles want 0", en_cycles); end
        bus_if.i_fval = 0;
        cyc(HOLD);
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_gap_wait: got %0d want 0", bus_if.o_enable); end
        cyc(1);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL cont_enable_in_gap: got %0d want 1", bus_if.o_enable); end
        cyc(L);
        for (int f = 1; f <= 3; f++) begin
            bus_if.i_fval = 1;
            cyc(H);
            n_checks++; if (bus_if.o_full_frame_state !== 1'b1) begin n_fail++; $display("[TB] FAIL cont_full_%0d: got %0d want 1", f, bus_if.o_full_frame_state); end
            bus_if.i_fval = 0;
            cyc(D);
            n_checks++; if (bus_if.ov_frame_cnt !== 16'(f)) begin n_fail++; $display("[TB] FAIL cont_cnt_%0d: got %0d want %0d", f, bus_if.ov_frame_cnt, f); end
            if (f == 1) begin
                n_checks++; if (bus_if.o_full_frame_state !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_full_clear: got %0d want 0", bus_if.o_full_frame_state); end
            end
            cyc(L - D);
        end
        n_checks++; if (full_rises !== 3) begin n_fail++; $display("[TB] FAIL cont_frames: got %0d want 3", full_rises); end
        bus_if.i_acquisition_start = 0;
        cyc(2);
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_stop: got %0d want 0", bus_if.o_enable); end
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL cont_cnt_hold: got %0d want 3", bus_if.ov_frame_cnt); end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("[TB] FAIL cont_no_done: got %0d pulses want 0", done_seen); end
    endtask

    task automatic test_multi_frame();
        bus_if.iv_acq_mode = 2; bus_if.iv_frame_num = 3;
        done_seen = 0; full_rises = 0;
        bus_if.i_acquisition_start = 1;
        cyc(3);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_arm: got %0d want 1", bus_if.o_enable); end
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL multi_cnt_start: got %0d want 0", bus_if.ov_frame_cnt); end
        for (int f = 1; f <= 4; f++) begin
            bus_if.i_fval = 1;
            cyc(H);
            bus_if.i_fval = 0;
            cyc(D);
            if (f == 3) begin
                n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_enable_drop: got %0d want 0", bus_if.o_enable); end
                n_checks++; if (bus_if.o_acq_done !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_done_pulse: got %0d want 1", bus_if.o_acq_done); end
                n_checks++; if (bus_if.ov_frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL multi_cnt3: got %0d want 3", bus_if.ov_frame_cnt); end
                cyc(1);
                n_checks++; if (bus_if.o_acq_done !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_done_width: got %0d want 0", bus_if.o_acq_done); end
                cyc(L - D - 1);
            end else begin
                cyc(L - D);
            end
        end
        n_checks++; if (full_rises !== 3) begin n_fail++; $display("[TB] FAIL multi_frames: got %0d want 3", full_rises); end
        n_checks++; if (done_seen !== 1) begin n_fail++; $display("[TB] FAIL multi_done_count: got %0d want 1", done_seen); end
        n_checks++; if (en_cycles >= 0 && bus_if.ov_frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL multi_cnt_after: got %0d want 3", bus_if.ov_frame_cnt); end
        bus_if.i_acquisition_start = 0;
        cyc(2);
        bus_if.i_acquisition_start = 1;
        cyc(3);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL multi_rearm: got %0d want 1", bus_if.o_enable); end
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL multi_rearm_cnt: got %0d want 0", bus_if.ov_frame_cnt); end
        bus_if.i_fval = 1;
        cyc(H);
        bus_if.i_fval = 0;
        cyc(D);
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL multi_rearm_cnt1: got %0d want 1", bus_if.ov_frame_cnt); end
        cyc(L - D);
    endtask

    task automatic test_stream_enable_drop();
        done_seen = 0;
        bus_if.i_fval = 1;
        cyc(20);
        bus_if.i_stream_enable = 0;
        cyc(H - 20);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_hold: got %0d want 1", bus_if.o_enable); end
        bus_if.i_fval = 0;
        cyc(HOLD);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_until_fall: got %0d want 1", bus_if.o_enable); end
        cyc(1);
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_release: got %0d want 0", bus_if.o_enable); end
        n_checks++; if (bus_if.o_full_frame_state !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_full_clear: got %0d want 0", bus_if.o_full_frame_state); end
        cyc(L);
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("[TB] FAIL drain_no_done: got %0d pulses want 0", done_seen); end
    endtask

    task automatic test_shadow();
        bus_if.iv_pixel_format = 32'h0108; bus_if.iv_test_image_sel = 3'd3;
        cyc(1);
        n_checks++; if (bus_if.ov_pixel_format !== 32'h0108) begin n_fail++; $display("[TB] FAIL shadow_load: got %0h want 108", bus_if.ov_pixel_format); end
        bus_if.i_fval = 1;
        cyc(5);
        bus_if.iv_pixel_format = 32'h0110; bus_if.iv_test_image_sel = 3'd5;
        cyc(10);
        n_checks++; if (bus_if.ov_pixel_format !== 32'h0108) begin n_fail++; $display("[TB] FAIL shadow_frozen: got %0h want 108", bus_if.ov_pixel_format); end
        n_checks++; if (bus_if.ov_test_image_sel !== 3'd3) begin n_fail++; $display("[TB] FAIL shadow_tis_frozen: got %0d want 3", bus_if.ov_test_image_sel); end
        bus_if.i_fval = 0;
        cyc(HOLD);
        n_checks++; if (bus_if.ov_pixel_format !== 32'h0108) begin n_fail++; $display("[TB] FAIL shadow_hold_gap: got %0h want 108", bus_if.ov_pixel_format); end
        cyc(1);
        n_checks++; if (bus_if.ov_pixel_format !== 32'h0110) begin n_fail++; $display("[TB] FAIL shadow_update: got %0h want 110", bus_if.ov_pixel_format); end
        n_checks++; if (bus_if.ov_test_image_sel !== 3'd5) begin n_fail++; $display("[TB] FAIL shadow_tis_update: got %0d want 5", bus_if.ov_test_image_sel); end
        cyc(L);
    endtask

    task automatic test_encrypt_block();
        bus_if.i_encrypt_state = 0; bus_if.i_stream_enable = 1; bus_if.iv_acq_mode = 0;
        en_cycles = 0;
        cyc(L);
        bus_if.i_fval = 1;
        cyc(H);
        bus_if.i_fval = 0;
        cyc(L);
        n_checks++; if (en_cycles !== 0) begin n_fail++; $display("[TB] FAIL encrypt_block: got %0d cycles want 0", en_cycles); end
    endtask

    task automatic test_frame_num_zero();
        bus_if.i_acquisition_start = 0; bus_if.i_encrypt_state = 1;
        bus_if.iv_acq_mode = 2; bus_if.iv_frame_num = 0;
        cyc(2);
        done_seen = 0; full_rises = 0;
        bus_if.i_acquisition_start = 1;
        cyc(3);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_arm: got %0d want 1", bus_if.o_enable); end
        for (int f = 1; f <= 2; f++) begin
            bus_if.i_fval = 1;
            cyc(H);
            bus_if.i_fval = 0;
            cyc(D);
            if (f == 1) begin
                n_checks++; if (bus_if.o_acq_done !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_done: got %0d want 1", bus_if.o_acq_done); end
                n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_enable_drop: got %0d want 0", bus_if.o_enable); end
                n_checks++; if (bus_if.ov_frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL zero_cnt: got %0d want 1", bus_if.ov_frame_cnt); end
            end
            cyc(L - D);
        end
        n_checks++; if (full_rises !== 1) begin n_fail++; $display("[TB] FAIL zero_frames: got %0d want 1", full_rises); end
        n_checks++; if (done_seen !== 1) begin n_fail++; $display("[TB] FAIL zero_done_count: got %0d want 1", done_seen); end
    endtask

    task automatic test_reset_mid_frame();
        bus_if.iv_acq_mode = 0;
        cyc(3);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_arm: got %0d want 1", bus_if.o_enable); end
        bus_if.i_fval = 1;
        cyc(H);
        bus_if.i_fval = 0;
        cyc(D);
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL rst_pre_cnt: got %0d want 1", bus_if.ov_frame_cnt); end
        cyc(L - D);
        bus_if.i_fval = 1;
        cyc(10);
        n_checks++; if (bus_if.o_full_frame_state !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_full: got %0d want 1", bus_if.o_full_frame_state); end
        reset_pix = 1;
        #1;
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_enable: got %0d want 0", bus_if.o_enable); end
        n_checks++; if (bus_if.o_full_frame_state !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_full: got %0d want 0", bus_if.o_full_frame_state); end
        n_checks++; if (bus_if.ov_frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_async_cnt: got %0d want 0", bus_if.ov_frame_cnt); end
        n_checks++; if (bus_if.ov_pixel_format !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_async_fmt: got %0h want 0", bus_if.ov_pixel_format); end
        n_checks++; if (bus_if.ov_test_image_sel !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_async_tis: got %0d want 0", bus_if.ov_test_image_sel); end
        reset_pix = 0;
        cyc(HOLD + 10);
        n_checks++; if (bus_if.o_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_partial: got %0d want 0", bus_if.o_enable); end
        bus_if.i_fval = 0;
        cyc(1);
        n_checks++; if (bus_if.o_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_rearm_gap: got %0d want 1", bus_if.o_enable); end
        cyc(L);
    endtask

    initial begin
        test_reset();
        test_cont_mid_frame();
        test_multi_frame();
        test_stream_enable_drop();
        test_shadow();
        test_encrypt_block();
        test_frame_num_zero();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_ctrl_mf.md
Name: stream_ctrl_mf

Overview:
Parametrised successor of the frame-boundary stream gate. Gates the pixel stream so only whole frames pass and shadows the format/test-image registers at frame gaps. Adds continuous, single-frame and multi-frame acquisition modes, a frame counter and a done pulse. Sits between the sensor interface and the downstream pixel pipeline in the clk_pix domain.

Parameters:
REG_WD, 32, width of the pixel-format register
TIS_WD, 3, width of the test-image select
FCNT_WD, 16, width of the frame-number and frame-counter fields
FVAL_HOLD, 20, clk_pix cycles FVAL is extended by when STREAM_CTRL_FVAL_HOLD_EN is defined

Ports:
clk_pix  in  1  pixel clock; sole clock
reset_pix  in  1  asynchronous active-high reset
i_fval  in  1  sensor frame valid
i_acquisition_start  in  1  acquisition command level
i_stream_enable  in  1  stream enable level
i_encrypt_state  in  1  1 = licence ok; 0 blocks streaming
iv_acq_mode  in  2  0 continuous, 1 single frame, 2 multi-frame, 3 treated as 0
iv_frame_num  in  FCNT_WD  frames per multi-frame acquisition; 0 treated as 1
iv_pixel_format  in  REG_WD  pixel format register
iv_test_image_sel  in  TIS_WD  test image select
o_enable  out  1  stream pass enable
o_full_frame_state  out  1  1 while an enabled frame is in progress
ov_pixel_format  out  REG_WD  frame-stable pixel format
ov_test_image_sel  out  TIS_WD  frame-stable test image select
ov_frame_cnt  out  FCNT_WD  frames completed since arm, saturating
o_acq_done  out  1  one-cycle pulse when single/multi acquisition completes

Behaviour:
- Reset: all outputs 0; FSM IDLE; acq_start edge register 0.
- fval_g = gap-detect FVAL: raw i_fval, or extended per the optional feature. fval_fall = registered fval_g 1 -> 0.
- go = i_acquisition_start & i_stream_enable & i_encrypt_state.
- FSM IDLE: go, plus (mode 0, or rising edge of i_acquisition_start seen since the last done) -> ARMED. On entry ov_frame_cnt <= 0.
- ARMED: go = 0 -> IDLE. go & fval_g = 0 -> ACTIVE, o_enable = 1 the next cycle.
- ACTIVE: o_full_frame_state = 1 from the cycle after i_fval rises until the cycle after fval_g falls.
- ACTIVE, at fval_fall: ov_frame_cnt increments, saturating at all ones.
- ACTIVE stop request: go drops, or (mode 1/2 and count reaches target). Target = 1 for mode 1, max(iv_frame_num, 1) for mode 2.
- Stop with fval_g = 0: o_enable = 0 next cycle, FSM -> IDLE.
- Stop with fval_g = 1: FSM -> DRAIN. Hold o_enable until fval_fall, then drop it and go to IDLE. The frame is never truncated.
- Count-triggered stop: o_acq_done pulses 1 cycle, coincident with o_enable falling.
- Count reached exactly at fval_fall: no DRAIN; o_enable falls the next cycle.
- Shadow registers: ov_pixel_format and ov_test_image_sel load from the inputs every cycle fval_g = 0. They are frozen while fval_g = 1. Latency 1 cycle.
- iv_acq_mode and the target are sampled on ARMED -> ACTIVE and held for the whole acquisition.
- Mode 0 never pulses o_acq_done. Its counter still runs.
- i_fval already high when go asserts: stay ARMED until the gap. A partial frame is never enabled.
- Reset mid-frame: immediate return to reset values, asynchronously.

Optional Feature:
- Macro: STREAM_CTRL_FVAL_HOLD_EN.
- Defined: fval_g = i_fval OR (i_fval delayed through a FVAL_HOLD-deep shift register). The gap is seen only after FVAL_HOLD idle cycles, so enable and shadow changes stay clear of trailing line/pipeline data.
- Undefined: fval_g = i_fval; no shift register.

Decomposition:
- Package stream_ctrl_pkg: acq-mode constants ACQ_CONT=0, ACQ_SINGLE=1, ACQ_MULTI=2; FSM state encoding IDLE/ARMED/ACTIVE/DRAIN.
- One sub-module, fval_gap_det: optional hold shift register plus fall-edge detector, producing fval_g and fval_fall.

Test Plan:
- Mode 0, go = 1 mid-frame (fval high 1000 cycles, low 200) -> o_enable rises in the first gap, never mid-frame; ov_frame_cnt = 1, 2, 3 after successive frames.
- Mode 2, iv_frame_num = 3 -> exactly 3 enabled frames; o_acq_done one pulse with o_enable falling; 4th frame blocked. A new acquisition_start rising edge re-arms and the counter restarts at 0.
- i_stream_enable dropped 100 cycles into a frame -> o_enable held until that frame's fval fall + 1, then 0; no done pulse.
- iv_pixel_format changed 0x0108 -> 0x0110 mid-frame -> ov_pixel_format stays 0x0108 until the gap (plus FVAL_HOLD when the macro is defined).
- i_encrypt_state = 0 with go otherwise true -> o_enable never asserts; mode 2 with iv_frame_num = 0 -> exactly 1 frame, then done.
- Assert reset_pix mid-frame while ACTIVE -> all outputs 0 immediately. Release -> re-arm only at the next gap.
